// File: rtl/regs_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regs_file_sb
//  Purpose  : Parametrised register file with one synchronous write port,
//             two combinational read ports, optional write-to-read bypass,
//             selectable reset contents, optional hardwired zero register and
//             a per-register busy scoreboard with a registered busy count.
//  Revision : 1.0 - initial release
// ============================================================================
module regs_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RST_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              SB_SET,
  input  logic [ADDR_W-1:0] SB_A,
  output logic [ADDR_W:0]   BUSY_CNT
);

  localparam int c_depth = 2**ADDR_W;

  logic [DATA_W-1:0]  r_regs [c_depth];
  logic [c_depth-1:0] r_busy;
  logic [c_depth-1:0] w_busy_nxt;
  logic [ADDR_W:0]    r_busy_cnt;
  logic [ADDR_W:0]    w_busy_cnt_nxt;
  logic               w_wr_ok;
  logic               w_set_ok;
  logic               w_cnt_inc;
  logic               w_cnt_dec;

  // Reset contents of register idx: either zero or its own index.
  function automatic logic [DATA_W-1:0] f_rst_val(input int idx);
    if (RST_MODE != 0) begin
      return DATA_W'(idx);
    end
    return '0;
  endfunction

  // Register 0 is read-only when it is the hardwired zero register.
  function automatic logic f_writable(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG == 0) || (addr != '0);
  endfunction

  // Qualified write/set requests; gated by rst_n so nothing forwards or
  // updates while reset is held.
  assign w_wr_ok  = rst_n && WE3    && f_writable(A3);
  assign w_set_ok = rst_n && SB_SET && f_writable(SB_A);

  // Next busy vector and incremental count change; a set to the same
  // register as a write-clear wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[A3]   = 1'b0;
    if (w_set_ok) w_busy_nxt[SB_A] = 1'b1;
    w_cnt_inc = w_set_ok && !r_busy[SB_A];
    w_cnt_dec = w_wr_ok && r_busy[A3] && !(w_set_ok && (SB_A == A3));
    w_busy_cnt_nxt = r_busy_cnt;
    if (w_cnt_inc && !w_cnt_dec) begin
      w_busy_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(1);
    end else if (w_cnt_dec && !w_cnt_inc) begin
      w_busy_cnt_nxt = r_busy_cnt - (ADDR_W+1)'(1);
    end
  end

  // Register storage: reset contents on rst_n, otherwise synchronous write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= f_rst_val(i);
      end
    end else if (w_wr_ok) begin
      r_regs[A3] <= WD3;
    end
  end

  // Scoreboard bits and their population count update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign BUSY_CNT = r_busy_cnt;

  // Read port 1: stored state, then same-cycle forwarding, then zero register.
  always_comb begin
    RD1   = r_regs[A1];
    BUSY1 = r_busy[A1];
    if ((BYPASS != 0) && w_wr_ok && (A3 == A1)) begin
      RD1   = WD3;
      BUSY1 = 1'b0;
    end
    if ((ZERO_REG != 0) && (A1 == '0)) begin
      RD1   = '0;
      BUSY1 = 1'b0;
    end
  end

  // Read port 2: resolved independently of port 1.
  always_comb begin
    RD2   = r_regs[A2];
    BUSY2 = r_busy[A2];
    if ((BYPASS != 0) && w_wr_ok && (A3 == A2)) begin
      RD2   = WD3;
      BUSY2 = 1'b0;
    end
    if ((ZERO_REG != 0) && (A2 == '0)) begin
      RD2   = '0;
      BUSY2 = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regs_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regs_file_sb
//  Purpose  : Self-checking bench for regs_file_sb (bypass and non-bypass
//             instances sharing one stimulus and one reference model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regs_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  A1 = '0, A2 = '0, A3 = '0, SB_A = '0;
  logic [31:0] WD3 = '0;
  logic        WE3 = 1'b0, SB_SET = 1'b0;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy1, busy2, nb_busy1, nb_busy2;
  logic [5:0]  busy_cnt, nb_busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [32];
  bit          m_busy[32];

  regs_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .RST_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(rd1), .RD2(rd2),
    .BUSY1(busy1), .BUSY2(busy2), .WE3(WE3), .A3(A3), .WD3(WD3),
    .SB_SET(SB_SET), .SB_A(SB_A), .BUSY_CNT(busy_cnt)
  );

  regs_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0), .RST_MODE(1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(nb_rd1), .RD2(nb_rd2),
    .BUSY1(nb_busy1), .BUSY2(nb_busy2), .WE3(WE3), .A3(A3), .WD3(WD3),
    .SB_SET(SB_SET), .SB_A(SB_A), .BUSY_CNT(nb_busy_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'(i);
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    if (!rst_n) return;
    if (WE3 && A3 != 0) begin
      m_reg[A3]  = WD3;
      m_busy[A3] = 1'b0;
    end
    if (SB_SET && SB_A != 0) m_busy[SB_A] = 1'b1;
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && rst_n && WE3 && A3 == a) return WD3;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (!rst_n) return 1'b0;
    if (byp && WE3 && A3 == a) return 1'b0;
    return m_busy[a];
  endfunction

  // One clock edge with the model following it; inputs go idle afterwards.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    WE3 = 1'b0;
    SB_SET = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    WE3 = 1'b1; A3 = 5'd7; WD3 = $urandom | 32'h100; SB_SET = 1'b1; SB_A = 5'd7;
    cycle();
    A1 = 5'd7; A2 = 5'd31;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rd1 !== 32'h7) begin errors++; $display("FAIL reset_rd1: got %h expected %h", rd1, 32'h7); end
    checks++; if (rd2 !== 32'h1F) begin errors++; $display("FAIL reset_rd2: got %h expected %h", rd2, 32'h1F); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_bypass();
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; A1 = 5'd5;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_same_cycle: got %h expected %h", rd1, 32'hDEADBEEF); end
    checks++; if (nb_rd1 !== 32'h5) begin errors++; $display("FAIL nobyp_before_edge: got %h expected %h", nb_rd1, 32'h5); end
    cycle();
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_after_edge: got %h expected %h", rd1, 32'hDEADBEEF); end
    checks++; if (nb_rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL nobyp_after_edge: got %h expected %h", nb_rd1, 32'hDEADBEEF); end
  endtask

  task automatic test_zero_reg();
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; SB_SET = 1'b1; SB_A = 5'd0; A1 = 5'd0;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_rd_pending: got %h expected 0", rd1); end
    cycle();
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_rd: got %h expected 0", rd1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy1); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_scoreboard();
    SB_SET = 1'b1; SB_A = 5'd3; cycle(); #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt1: got %0d expected 1", busy_cnt); end
    SB_SET = 1'b1; SB_A = 5'd4; cycle(); #1;
    checks++; if (busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_cnt2: got %0d expected 2", busy_cnt); end
    A1 = 5'd3; #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy1: got %b expected 1", busy1); end
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h12; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_bypass_clear: got %b expected 0", busy1); end
    checks++; if (nb_busy1 !== 1'b1) begin errors++; $display("FAIL sb_nobyp_busy: got %b expected 1", nb_busy1); end
    cycle(); #1;
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_after_clear: got %0d expected 1", busy_cnt); end
    checks++; if (rd1 !== 32'h12) begin errors++; $display("FAIL sb_wr_data: got %h expected %h", rd1, 32'h12); end
  endtask

  task automatic test_collision();
    logic [5:0] prev;
    SB_SET = 1'b1; SB_A = 5'd9; cycle(); #1;
    prev = busy_cnt;
    WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h55; SB_SET = 1'b1; SB_A = 5'd9; A1 = 5'd9;
    cycle(); #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b expected 1", busy1); end
    checks++; if (rd1 !== 32'h55) begin errors++; $display("FAIL coll_data: got %h expected %h", rd1, 32'h55); end
    checks++; if (busy_cnt !== prev) begin errors++; $display("FAIL coll_cnt_busy: got %0d expected %0d", busy_cnt, prev); end
    WE3 = 1'b1; A3 = 5'd10; WD3 = 32'h66; SB_SET = 1'b1; SB_A = 5'd10; A2 = 5'd10;
    cycle(); #1;
    checks++; if (busy_cnt !== prev + 6'd1) begin errors++; $display("FAIL coll_cnt_idle: got %0d expected %0d", busy_cnt, prev + 6'd1); end
    checks++; if (busy2 !== 1'b1 || rd2 !== 32'h66) begin errors++; $display("FAIL coll_reg10: got busy %b data %h expected busy 1 data %h", busy2, rd2, 32'h66); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      bit narrow = ($urandom_range(0, 1) == 1);
      WE3    = ($urandom_range(0, 99) < 45);
      SB_SET = ($urandom_range(0, 99) < 40);
      A3   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      SB_A = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      A1   = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      A2   = ($urandom_range(0, 3) == 0) ? A1 : (narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)));
      WD3  = $urandom;
      #1;
      checks++; if (rd1 !== exp_rd(A1, 1)) begin errors++; $display("FAIL rnd_rd1 it%0d: got %h expected %h", it, rd1, exp_rd(A1, 1)); end
      checks++; if (rd2 !== exp_rd(A2, 1)) begin errors++; $display("FAIL rnd_rd2 it%0d: got %h expected %h", it, rd2, exp_rd(A2, 1)); end
      checks++; if (busy1 !== exp_busy(A1, 1)) begin errors++; $display("FAIL rnd_busy1 it%0d: got %b expected %b", it, busy1, exp_busy(A1, 1)); end
      checks++; if (busy2 !== exp_busy(A2, 1)) begin errors++; $display("FAIL rnd_busy2 it%0d: got %b expected %b", it, busy2, exp_busy(A2, 1)); end
      checks++; if (nb_rd1 !== exp_rd(A1, 0)) begin errors++; $display("FAIL rnd_nb_rd1 it%0d: got %h expected %h", it, nb_rd1, exp_rd(A1, 0)); end
      checks++; if (nb_rd2 !== exp_rd(A2, 0)) begin errors++; $display("FAIL rnd_nb_rd2 it%0d: got %h expected %h", it, nb_rd2, exp_rd(A2, 0)); end
      checks++; if (nb_busy1 !== exp_busy(A1, 0)) begin errors++; $display("FAIL rnd_nb_busy1 it%0d: got %b expected %b", it, nb_busy1, exp_busy(A1, 0)); end
      checks++; if (nb_busy2 !== exp_busy(A2, 0)) begin errors++; $display("FAIL rnd_nb_busy2 it%0d: got %b expected %b", it, nb_busy2, exp_busy(A2, 0)); end
      cycle(); #1;
      checks++; if (busy_cnt !== 6'(exp_cnt())) begin errors++; $display("FAIL rnd_cnt it%0d: got %0d expected %0d", it, busy_cnt, exp_cnt()); end
      checks++; if (nb_busy_cnt !== 6'(exp_cnt())) begin errors++; $display("FAIL rnd_nb_cnt it%0d: got %0d expected %0d", it, nb_busy_cnt, exp_cnt()); end
    end
  endtask

  task automatic test_reset_mid();
    WE3 = 1'b1; A3 = 5'd20; WD3 = 32'hCAFE0000; cycle();
    for (int r = 11; r <= 16; r++) begin
      SB_SET = 1'b1; SB_A = 5'(r); cycle();
    end
    #1;
    checks++; if (busy_cnt !== 6'(exp_cnt())) begin errors++; $display("FAIL mid_pre_cnt: got %0d expected %0d", busy_cnt, exp_cnt()); end
    WE3 = 1'b1; A3 = 5'd21; WD3 = 32'hA5A5A5A5; SB_SET = 1'b1; SB_A = 5'd22;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", busy_cnt); end
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i); #1;
      checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL mid_busy reg%0d: got %b%b expected 00", i, busy1, busy2); end
      checks++; if (rd1 !== 32'(i)) begin errors++; $display("FAIL mid_rd reg%0d: got %h expected %h", i, rd1, 32'(i)); end
    end
    WE3 = 1'b0; SB_SET = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(); #1;
    A1 = 5'd20; A2 = 5'd21; #1;
    checks++; if (rd1 !== 32'd20 || rd2 !== 32'd21) begin errors++; $display("FAIL mid_after: got %h %h expected %h %h", rd1, rd2, 32'd20, 32'd21); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL mid_after_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_saturation();
    for (int r = 1; r < 32; r++) begin
      SB_SET = 1'b1; SB_A = 5'(r); cycle();
    end
    #1;
    checks++; if (busy_cnt !== 6'd31) begin errors++; $display("FAIL sat_cnt: got %0d expected 31", busy_cnt); end
    SB_SET = 1'b1; SB_A = 5'd17; cycle(); #1;
    checks++; if (busy_cnt !== 6'd31) begin errors++; $display("FAIL sat_reset_busy: got %0d expected 31", busy_cnt); end
    SB_SET = 1'b1; SB_A = 5'd0; WE3 = 1'b1; A3 = 5'd0; WD3 = 32'h1; cycle(); #1;
    checks++; if (busy_cnt !== 6'd31) begin errors++; $display("FAIL sat_zero: got %0d expected 31", busy_cnt); end
    WE3 = 1'b1; A3 = 5'd30; WD3 = 32'h30; cycle(); #1;
    checks++; if (busy_cnt !== 6'd30) begin errors++; $display("FAIL sat_clear: got %0d expected 30", busy_cnt); end
    WE3 = 1'b1; A3 = 5'd30; WD3 = 32'h31; cycle(); #1;
    checks++; if (busy_cnt !== 6'd30) begin errors++; $display("FAIL sat_clear_idle: got %0d expected 30", busy_cnt); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
